// File: rtl/sar_search_pkg.sv
// Shared types and sizing helpers for the SAR search engine.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam int WIDTH_DEF = 4;

  function automatic int steps_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator-side and control bundle for sar_search.
// Carries err when SAR_ONEHOT_CHECK_EN is defined.
interface sar_search_if
  import sar_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) ();

   localparam int SW = steps_w(WIDTH);

   logic             start;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;
   logic [WIDTH-1:0] probe;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             found;
   logic [SW-1:0]    steps;
`ifdef SAR_ONEHOT_CHECK_EN
   logic             err;

   modport master (
      output start, cmp_gt, cmp_eq, cmp_lt,
      input  probe, busy, done, result, found, steps, err
   );
   modport slave (
      input  start, cmp_gt, cmp_eq, cmp_lt,
      output probe, busy, done, result, found, steps, err
   );
`else
   modport master (
      output start, cmp_gt, cmp_eq, cmp_lt,
      input  probe, busy, done, result, found, steps
   );
   modport slave (
      input  start, cmp_gt, cmp_eq, cmp_lt,
      output probe, busy, done, result, found, steps
   );
`endif

endinterface

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against a 3-way comparator.
// Define SAR_ONEHOT_CHECK_EN to abort on non-one-hot flags (err output).
module sar_search
  import sar_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic        clk,
   input logic        rst,
   sar_search_if.slave bus
);

   localparam int SW = steps_w(WIDTH);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] trial;
   logic [IW-1:0]    idx;
   logic [SW-1:0]    cnt;

   logic             fin;
   logic [WIDTH-1:0] fin_res;
   logic             fin_found;
   logic [WIDTH-1:0] nxt;
   logic             bad;

`ifdef SAR_ONEHOT_CHECK_EN
   logic             err;
   assign bad     = !$onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});
   assign bus.err = err;
`else
   logic unused_lt;
   assign bad       = 1'b0;
   assign unused_lt = bus.cmp_lt;
`endif

   // trial is zero outside SEARCH, so probe idles at 0
   assign bus.probe = trial;

   always_comb begin
      fin       = 1'b0;
      fin_res   = trial;
      fin_found = 1'b0;
      nxt       = trial;
      if (bad) begin
         fin     = 1'b1;
         fin_res = '0;
      end else if (bus.cmp_eq) begin
         fin       = 1'b1;
         fin_found = 1'b1;
      end else if (bus.cmp_gt) begin
         if (idx == '0) fin = 1'b1;
         else nxt = trial | (ONE << (idx - IW'(1)));
      end else begin
         if (idx == '0) begin
            fin     = 1'b1;
            fin_res = trial & ~ONE;
         end else begin
            nxt = (trial & ~(ONE << idx)) | (ONE << (idx - IW'(1)));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         trial      <= '0;
         idx        <= TOP;
         cnt        <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.found  <= 1'b0;
         bus.steps  <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
         err        <= 1'b0;
`endif
      end else begin
         bus.done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= SEARCH;
                  trial      <= ONE << TOP;
                  idx        <= TOP;
                  cnt        <= '0;
                  bus.busy   <= 1'b1;
                  bus.result <= '0;
                  bus.found  <= 1'b0;
                  bus.steps  <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
                  err        <= 1'b0;
`endif
               end
            end
            SEARCH: begin
               cnt <= cnt + SW'(1);
               if (fin) begin
                  state      <= DONE;
                  trial      <= '0;
                  idx        <= TOP;
                  bus.busy   <= 1'b0;
                  bus.done   <= 1'b1;
                  bus.result <= fin_res;
                  bus.found  <= fin_found;
                  bus.steps  <= cnt + SW'(1);
`ifdef SAR_ONEHOT_CHECK_EN
                  err        <= bad;
`endif
               end else begin
                  trial <= nxt;
                  idx   <= idx - IW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search.sv
// Directed-vector bench for sar_search (WIDTH=4) with a comparator model.
// Honors SAR_ONEHOT_CHECK_EN for the err path.
module tb_sar_search;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] target = '0;
   logic       ovr = 1'b0;
   int         total = 0;
   int         bad = 0;

   sar_search_if #(.WIDTH(4)) bus ();

   sar_search #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // comparator model; ovr forces gt and eq together
   always_comb begin
      bus.cmp_gt = ovr ? 1'b1 : (target > bus.probe);
      bus.cmp_eq = ovr ? 1'b1 : (target == bus.probe);
      bus.cmp_lt = ovr ? 1'b0 : (target < bus.probe);
   end

   typedef struct {
      logic [3:0]  tgt;
      logic [15:0] pseq;
      int          lat;
      logic [3:0]  res;
      logic        fnd;
      int          stp;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic run(input logic [3:0] t, output int lat,
                      output logic [15:0] pseq, output logic to);
      target = t;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat  = 1;
      pseq = '0;
      to   = 1'b0;
      while (!bus.done && lat < 20) begin
         pseq = {pseq[11:0], bus.probe};
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.done) to = 1'b1;
   endtask

   vec_t        v [8];
   int          lat;
   logic [15:0] pseq;
   logic        to;
   int          seen;

   initial begin
      bus.start = 1'b0;
      v[0] = '{4'd5,  16'h8465, 5, 4'd5,  1'b1, 4};
      v[1] = '{4'd8,  16'h0008, 2, 4'd8,  1'b1, 1};
      v[2] = '{4'd0,  16'h8421, 5, 4'd0,  1'b0, 4};
      v[3] = '{4'd15, 16'h8CEF, 5, 4'd15, 1'b1, 4};
      v[4] = '{4'd10, 16'h08CA, 4, 4'd10, 1'b1, 3};
      v[5] = '{4'd3,  16'h8423, 5, 4'd3,  1'b1, 4};
      v[6] = '{4'd14, 16'h08CE, 4, 4'd14, 1'b1, 3};
      v[7] = '{4'd1,  16'h8421, 5, 4'd1,  1'b1, 4};

      #1;
      chk("rst_probe", bus.probe, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_found", bus.found, 0);
      chk("rst_steps", bus.steps, 0);
`ifdef SAR_ONEHOT_CHECK_EN
      chk("rst_err", bus.err, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run(v[i].tgt, lat, pseq, to);
         chk($sformatf("timeout_t%0d", v[i].tgt), to, 0);
         chk($sformatf("probes_t%0d", v[i].tgt), pseq, v[i].pseq);
         chk($sformatf("latency_t%0d", v[i].tgt), lat, v[i].lat);
         chk($sformatf("result_t%0d", v[i].tgt), bus.result, v[i].res);
         chk($sformatf("found_t%0d", v[i].tgt), bus.found, v[i].fnd);
         chk($sformatf("steps_t%0d", v[i].tgt), bus.steps, v[i].stp);
         chk($sformatf("busy_done_t%0d", v[i].tgt), bus.busy, 0);
         @(posedge clk);
         #1;
         chk($sformatf("pulse_t%0d", v[i].tgt), bus.done, 0);
         chk($sformatf("hold_t%0d", v[i].tgt), bus.result, v[i].res);
      end

      // reset during the second SEARCH cycle
      target = 4'd5;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_probe_pre", bus.probe, 4);
      rst = 1'b1;
      #1;
      chk("mid_probe", bus.probe, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_done", bus.done, 0);
      chk("mid_result", bus.result, 0);
      chk("mid_found", bus.found, 0);
      chk("mid_steps", bus.steps, 0);
      seen = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.done) seen++;
      end
      chk("mid_no_done", seen, 0);
      @(negedge clk);
      rst = 1'b0;
      run(4'd5, lat, pseq, to);
      chk("after_rst_latency", lat, 5);
      chk("after_rst_result", bus.result, 5);
      chk("after_rst_found", bus.found, 1);
      @(posedge clk);
      #1;

      // gt and eq both high on the first probe
      ovr = 1'b1;
      run(4'd3, lat, pseq, to);
      ovr = 1'b0;
      chk("ovr_latency", lat, 2);
      chk("ovr_steps", bus.steps, 1);
`ifdef SAR_ONEHOT_CHECK_EN
      chk("ovr_err", bus.err, 1);
      chk("ovr_result", bus.result, 0);
      chk("ovr_found", bus.found, 0);
      @(posedge clk);
      #1;
      run(4'd8, lat, pseq, to);
      chk("err_clear", bus.err, 0);
      chk("err_clear_result", bus.result, 8);
`else
      chk("ovr_result", bus.result, 8);
      chk("ovr_found", bus.found, 1);
`endif
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
